// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, RAM and status signals shared by mem_port_arbiter and its environment.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    grant;
  logic          busy;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata,
           grant, busy
  );

  // Requester / RAM side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata,
           grant, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the CPU port (0) and loader port (1).
// One transaction at a time: IDLE -> ISSUE -> [WAIT] -> ACK -> IDLE, all outputs registered.
module mem_port_arbiter #(
  parameter int unsigned AW      = 9,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clock,
  input  logic               clear_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned    CW       = 2;
  localparam logic [CW-1:0]  LAT_LOAD = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic            busy_q, busy_d;
  logic            pick;

  // Winner: on a tie the port not served last; otherwise whichever is requesting.
  assign pick = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

  // State register and registered outputs
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_d     = pick ? 2'b10 : 2'b01;
          mem_en_d    = 1'b1;
          mem_we_d    = pick ? bus.we1    : bus.we0;
          mem_addr_d  = pick ? bus.addr1  : bus.addr0;
          mem_wdata_d = pick ? bus.wdata1 : bus.wdata0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          ack0_d  = grant_q[0];
          ack1_d  = grant_q[1];
          state_d = ACK;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (grant_q[1]) rdata1_d = bus.mem_rdata;
          else            rdata0_d = bus.mem_rdata;
          ack0_d  = grant_q[0];
          ack1_d  = grant_q[1];
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACK: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=1 instance with per-port expectation queues,
// plus a MEM_LAT=3 instance exercised directly.
module tb_mem_port_arbiter;

  typedef struct {
    bit          we;
    logic [8:0]  addr;
    logic [31:0] data;
    int          exp_lat;
  } op_t;

  logic clk = 1'b0;
  logic clear_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(9), .DW(32)) ifa ();
  mem_port_arbiter_if #(.AW(9), .DW(32)) ifb ();

  mem_port_arbiter #(.AW(9), .DW(32), .MEM_LAT(1)) dut_a (.clock(clk), .clear_n(clear_n), .bus(ifa));
  mem_port_arbiter #(.AW(9), .DW(32), .MEM_LAT(3)) dut_b (.clock(clk), .clear_n(clear_n), .bus(ifb));

  // RAM models: read data only valid in exactly the cycle MEM_LAT after the strobe
  logic [31:0] ram_a [512];
  logic [31:0] ram_b [512];
  logic        va;
  logic [31:0] da;
  logic        vb [3];
  logic [31:0] db [3];

  always @(posedge clk) begin
    if (ifa.mem_en && ifa.mem_we) ram_a[ifa.mem_addr] <= ifa.mem_wdata;
    va <= ifa.mem_en && !ifa.mem_we;
    da <= ram_a[ifa.mem_addr];
  end
  assign ifa.mem_rdata = va ? da : 32'h5A5A_5A5A;

  always @(posedge clk) begin
    if (ifb.mem_en && ifb.mem_we) ram_b[ifb.mem_addr] <= ifb.mem_wdata;
    vb[0] <= ifb.mem_en && !ifb.mem_we;
    db[0] <= ram_b[ifb.mem_addr];
    vb[1] <= vb[0];
    db[1] <= db[0];
    vb[2] <= vb[1];
    db[2] <= db[1];
  end
  assign ifb.mem_rdata = vb[2] ? db[2] : 32'h5A5A_5A5A;

  int          n_vec = 0;
  int          n_err = 0;
  op_t         pend0[$];
  op_t         pend1[$];
  op_t         cur [2];
  bit          active [2];
  int          t0 [2];
  logic [31:0] exp_rd [2];
  logic [31:0] gold [512];
  int          en_cnt = 0;
  int          gseq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_wr(input int p, input logic [8:0] a, input logic [31:0] d, input int lat);
    op_t o;
    o.we = 1'b1; o.addr = a; o.data = d; o.exp_lat = lat;
    gold[a] = d;
    if (p == 0) pend0.push_back(o); else pend1.push_back(o);
  endtask

  task automatic push_rd(input int p, input logic [8:0] a, input int lat);
    op_t o;
    o.we = 1'b0; o.addr = a; o.data = gold[a]; o.exp_lat = lat;
    if (p == 0) pend0.push_back(o); else pend1.push_back(o);
  endtask

  task automatic set_port(input int p, input bit r, input op_t o);
    if (p == 0) begin
      ifa.req0 = r; ifa.we0 = o.we; ifa.addr0 = o.addr; ifa.wdata0 = o.we ? o.data : 32'h0;
    end else begin
      ifa.req1 = r; ifa.we1 = o.we; ifa.addr1 = o.addr; ifa.wdata1 = o.we ? o.data : 32'h0;
    end
  endtask

  task automatic monitor();
    int g;
    int p;
    if (ifa.mem_en) begin
      en_cnt++;
      check("grant_onehot", 64'(ifa.grant == 2'b01 || ifa.grant == 2'b10), 1);
      g = int'(ifa.grant[1]);
      gseq.push_back(int'(ifa.grant));
      check("grant_requested", 64'(active[g]), 1);
      check("mem_addr", 64'(ifa.mem_addr), 64'(cur[g].addr));
      check("mem_we", 64'(ifa.mem_we), 64'(cur[g].we));
      if (cur[g].we) check("mem_wdata", 64'(ifa.mem_wdata), 64'(cur[g].data));
    end
    if (ifa.ack0 || ifa.ack1) begin
      check("ack_exclusive", 64'(ifa.ack0 && ifa.ack1), 0);
      p = int'(ifa.ack1);
      check("ack_expected", 64'(active[p]), 1);
      check("mem_en_once", 64'(en_cnt), 1);
      en_cnt = 0;
      if (!cur[p].we) exp_rd[p] = cur[p].data;
      check("rdata0", 64'(ifa.rdata0), 64'(exp_rd[0]));
      check("rdata1", 64'(ifa.rdata1), 64'(exp_rd[1]));
      if (cur[p].exp_lat >= 0) check("ack_latency", 64'(cyc - t0[p]), 64'(cur[p].exp_lat));
      active[p] = 1'b0;
    end
  endtask

  task automatic drive();
    op_t o;
    for (int p = 0; p < 2; p++) begin
      if (!active[p] && ((p == 0) ? pend0.size() : pend1.size()) != 0) begin
        o = (p == 0) ? pend0.pop_front() : pend1.pop_front();
        cur[p] = o;
        active[p] = 1'b1;
        t0[p] = cyc;
        set_port(p, 1'b1, o);
      end else if (!active[p]) begin
        if (p == 0) ifa.req0 = 1'b0; else ifa.req1 = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    drive();
  endtask

  task automatic run_done(input int max);
    int k;
    k = 0;
    while ((active[0] || active[1] || pend0.size() != 0 || pend1.size() != 0) && k < max) begin
      step();
      k++;
    end
    if (k >= max) check("run_timeout", 1, 0);
    step();
  endtask

  task automatic flush();
    pend0.delete();
    pend1.delete();
    active[0] = 1'b0;
    active[1] = 1'b0;
    ifa.req0 = 1'b0;
    ifa.req1 = 1'b0;
    en_cnt = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic do_reset();
    flush();
    clear_n = 1'b0;
    step();
    step();
    clear_n = 1'b1;
  endtask

  initial begin
    bit got;
    int tb0;
    int en_b;
    clear_n = 1'b0;
    ifa.req0 = 0; ifa.req1 = 0; ifa.we0 = 0; ifa.we1 = 0;
    ifa.addr0 = '0; ifa.addr1 = '0; ifa.wdata0 = '0; ifa.wdata1 = '0;
    ifb.req0 = 0; ifb.req1 = 0; ifb.we0 = 0; ifb.we1 = 0;
    ifb.addr0 = '0; ifb.addr1 = '0; ifb.wdata0 = '0; ifb.wdata1 = '0;
    do_reset();

    // Reset state
    check("rst_ack0", 64'(ifa.ack0), 0);
    check("rst_ack1", 64'(ifa.ack1), 0);
    check("rst_mem_en", 64'(ifa.mem_en), 0);
    check("rst_mem_we", 64'(ifa.mem_we), 0);
    check("rst_busy", 64'(ifa.busy), 0);
    check("rst_grant", 64'(ifa.grant), 0);
    check("rst_mem_addr", 64'(ifa.mem_addr), 0);
    check("rst_mem_wdata", 64'(ifa.mem_wdata), 0);
    check("rst_rdata0", 64'(ifa.rdata0), 0);
    check("rst_rdata1", 64'(ifa.rdata1), 0);

    // Single port-0 write, then port-1 read of the same word
    push_wr(0, 9'h012, 32'hDEAD_BEEF, 2);
    run_done(20);
    push_rd(1, 9'h012, 3);
    run_done(20);
    check("p1_read_data", 64'(ifa.rdata1), 64'h0000_0000_DEAD_BEEF);

    // Tie from reset: alternating grants over 6 writes, then 6 cross-port reads
    do_reset();
    gseq.delete();
    for (int i = 0; i < 3; i++) begin
      push_wr(0, 9'(9'h100 + i), 32'hA000_0000 + 32'(i), (i == 0) ? 2 : -1);
      push_wr(1, 9'(9'h1F0 + i), 32'hB000_0000 + 32'(i), (i == 0) ? 5 : -1);
    end
    run_done(60);
    for (int i = 0; i < 3; i++) begin
      push_rd(0, 9'(9'h1F0 + i), -1);
      push_rd(1, 9'(9'h100 + i), -1);
    end
    run_done(60);
    check("alt_count", 64'(gseq.size()), 12);
    for (int i = 0; i < 12 && i < gseq.size(); i++)
      check("alt_grant", 64'(gseq[i]), (i % 2 == 0) ? 1 : 2);

    // Reset while a read sits in WAIT
    push_rd(0, 9'h012, -1);
    step();
    step();
    step();
    flush();
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    check("wrst_busy", 64'(ifa.busy), 0);
    check("wrst_grant", 64'(ifa.grant), 0);
    check("wrst_ack", 64'({ifa.ack0, ifa.ack1}), 0);
    check("wrst_mem_en", 64'(ifa.mem_en), 0);
    repeat (4) step();
    gseq.delete();
    push_wr(0, 9'h040, 32'h1111_2222, 2);
    push_wr(1, 9'h041, 32'h3333_4444, 5);
    run_done(30);
    check("wrst_tie_first", (gseq.size() > 0) ? 64'(gseq[0]) : 64'hFF, 1);

    // Port-1 one-cycle pulse during port-0 ISSUE is ignored
    push_wr(0, 9'h050, 32'hCAFE_0001, 2);
    step();
    step();
    ifa.req1 = 1'b1; ifa.we1 = 1'b1; ifa.addr1 = 9'h051; ifa.wdata1 = 32'hBAD0_BAD0;
    step();
    ifa.req1 = 1'b0;
    run_done(20);
    repeat (4) step();
    // Port-1 read held from port-0 ISSUE: served after ack0 plus one IDLE cycle
    push_wr(0, 9'h060, 32'h0BAD_F00D, 2);
    step();
    push_rd(1, 9'h060, 5);
    run_done(30);
    check("held_rdata1", 64'(ifa.rdata1), 64'h0000_0000_0BAD_F00D);

    // MEM_LAT=3 instance: write then read
    ifb.req0 = 1'b1; ifb.we0 = 1'b1; ifb.addr0 = 9'h0A5; ifb.wdata0 = 32'h1357_9BDF;
    tb0 = cyc;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      if (ifb.ack0) got = 1'b1;
    end
    check("b_wr_ack_seen", 64'(got), 1);
    check("b_wr_latency", 64'(cyc - tb0), 2);
    ifb.req0 = 1'b0;
    step();
    step();
    ifb.req1 = 1'b1; ifb.we1 = 1'b0; ifb.addr1 = 9'h0A5;
    tb0 = cyc;
    got = 1'b0;
    en_b = 0;
    for (int k = 0; k < 16 && !got; k++) begin
      step();
      if (ifb.mem_en) en_b++;
      if (ifb.ack1) got = 1'b1;
    end
    ifb.req1 = 1'b0;
    check("b_rd_ack_seen", 64'(got), 1);
    check("b_rd_latency", 64'(cyc - tb0), 5);
    check("b_rd_mem_en_once", 64'(en_b), 1);
    check("b_rd_data", 64'(ifb.rdata1), 64'h0000_0000_1357_9BDF);
    check("b_rd_rdata0", 64'(ifb.rdata0), 0);
    step();
    check("b_ack_once", 64'(ifb.ack1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
